uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver, the link partner of the team's one-bit-per-clock UART transmitter: deserializes a frame on `rx` (start, LSB-first data, optional parity, stop) at one bit per `clk` cycle. It presents each received word, with parity and framing status, on a single-entry valid/ready holding register. It sits between the serial pin and the consumer logic in the same clock domain; no baud divider and no synchronizer.

## Interface
- `DATA_BITS`, default 8: data bits per frame; the transmitter partner uses 8.
- `clk`  in  1  clock; every bit time is one cycle.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial line, idle high.
- `parity_en`  in  1  frame carries a parity bit after the data.
- `even_parity`  in  1  parity mode select; see Operation.
- `rx_data`  out  DATA_BITS  received word; reset 0.
- `rx_valid`  out  1  holding register full; reset 0.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `parity_err`  out  1  parity mismatch for `rx_data`, qualified by `rx_valid`; reset 0.
- `frame_err`  out  1  stop bit sampled low for `rx_data`, qualified by `rx_valid`; reset 0.
- `overrun`  out  1  one-cycle pulse: an unaccepted word was overwritten; reset 0.
- `rx_busy`  out  1  high from the cycle after start detection until the stop bit is sampled; reset 0.

## Operation
- States: WAIT_IDLE, IDLE, DATA, PARITY, STOP.
- WAIT_IDLE:
  - Entered on reset and after a framing error.
  - Moves to IDLE once `rx` is sampled high.
  - No start bit is accepted in this state.
- IDLE:
  - `rx` sampled 0 is a start bit.
  - `parity_en` and `even_parity` are latched at this point; later changes do not affect the current frame.
  - Clears the bit counter and moves to DATA.
- DATA:
  - Samples `DATA_BITS` consecutive bits, LSB first, into a shift register.
  - After the last bit, moves to PARITY if latched `parity_en`, else to STOP.
- PARITY:
  - Samples one bit.
  - Expected parity is XNOR-reduce of the data when latched `even_parity`=1, XOR-reduce when 0. This matches the transmitter's encoding exactly.
  - Mismatch sets the pending `parity_err`.
  - Moves to STOP.
- STOP:
  - Samples the stop bit; 0 sets `frame_err`.
  - Loads `rx_data`, `parity_err`, `frame_err` and sets `rx_valid`.
  - Next state is IDLE if stop=1, WAIT_IDLE if stop=0.
  - A frame with errors is still delivered.
- With `parity_en`=0, `parity_err` is always 0.
- Handshake: `rx_valid` stays high until accepted; on acceptance it clears the next cycle unless a new word loads in that same cycle.
- Overrun: a load while `rx_valid && !rx_ready` overwrites data and flags, keeps `rx_valid`=1, and pulses `overrun` for one cycle. Load and accept in the same cycle is not an overrun: the new word replaces the accepted one.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values; the block enters WAIT_IDLE, so a data 0 on the line is not taken as a start bit.

## Timing
- Start bit sampled at cycle n; data bit k sampled at n+1+k.
- Parity bit at n+1+DATA_BITS, if enabled.
- Stop bit at n+1+DATA_BITS (+1 if parity enabled).
- `rx_valid`/`rx_data` registered: valid from the cycle after the stop bit is sampled, i.e. n+10 (8 bits, no parity) or n+11 (with parity).
- Back-to-back: a start bit in the cycle immediately after a good stop bit is accepted. The transmitter partner always inserts at least one idle cycle, and the receiver must not require it.
- `rx_busy` rises at n+1 and falls in the cycle after the stop sample.

## Structure
- Shared package `uart_pkg`:
  - state enum;
  - `DATA_BITS` default constant;
  - function `uart_parity(data, even)` returning the expected bit. The transmitter and receiver both use this function.
- Single flat module; no sub-module. The holding register is a few flops and does not warrant a separate block.

## Test plan
- 0xA5, `parity_en`=0, `rx_ready`=1 → `rx_valid` one cycle at n+10, `rx_data`=0xA5, both error flags 0.
- 0x3C, `parity_en`=1, `even_parity`=1, parity bit 1 → `parity_err`=0, valid at n+11. Repeat with parity bit 0 → `parity_err`=1.
- 0x55 with stop bit 0, `rx` held low 5 more cycles → word delivered with `frame_err`=1. No new frame until `rx` returns high and a fresh 0 arrives.
- Two frames 0x11, 0x22, back-to-back with no idle gap, `rx_ready`=0 → after the second frame `rx_data`=0x22, one-cycle `overrun` pulse, `rx_valid` still 1. Raising `rx_ready` clears `rx_valid` next cycle.
- Assert `rst` during data bit 3 of 0xF0, release with `rx`=0 → all outputs 0, no start detected until `rx`=1 then 0. A following 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and parity rule
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int MAX_DATA_BITS  = 32;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Expected parity bit, shared with the transmitter so both ends agree bit-for-bit.
  function automatic logic uart_parity(input logic [MAX_DATA_BITS-1:0] data, input logic even);
    return even ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - one-bit-per-clock UART receiver with single-entry holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 even_parity,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  state_t                   state;
  logic [CNT_W-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]     shift;
  logic                     par_en_q;
  logic                     even_q;
  logic                     par_pend;
  logic [MAX_DATA_BITS-1:0] shift_ext;

  assign shift_ext = MAX_DATA_BITS'(shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_en_q   <= 1'b0;
      even_q     <= 1'b0;
      par_pend   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        WAIT_IDLE: begin
          if (rx) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (!rx) begin
            par_en_q <= parity_en;
            even_q   <= even_parity;
            par_pend <= 1'b0;
            bit_cnt  <= '0;
            rx_busy  <= 1'b1;
            state    <= DATA;
          end
        end
        DATA: begin
          shift   <= {rx, shift[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
            state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_pend <= (rx != uart_parity(shift_ext, even_q));
          state    <= STOP;
        end
        STOP: begin
          // A new word always wins; it only counts as overrun if the old one was not taken this cycle.
          rx_data    <= shift;
          parity_err <= par_pend;
          frame_err  <= !rx;
          rx_valid   <= 1'b1;
          overrun    <= rx_valid && !rx_ready;
          rx_busy    <= 1'b0;
          state      <= rx ? IDLE : WAIT_IDLE;
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       parity_en = 1'b0;
  logic       even_parity = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  uart_rx #(.DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx(rx), .parity_en(parity_en), .even_parity(even_parity),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Transmitter convention: the parity bit is the inverse of "ones count is odd" when even=1.
  function automatic bit model_parity(input logic [7:0] d, input bit ev);
    return (($countones(d) % 2) == 1) ^ ev;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame starting in the current cycle; returns one cycle after the stop sample.
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit ev, input bit pbit,
                            input bit stop, input int rs);
    parity_en = pen; even_parity = ev; rx = 1'b0;
    tick();
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b expected 1", rx_busy); end
    parity_en = 1'($urandom); even_parity = 1'($urandom);
    for (int k = 0; k < 8; k++) begin rx = d[k]; tick(); end
    if (pen) begin rx = pbit; tick(); end
    rx = stop;
    if (rs >= 0) rx_ready = rs[0];
    tick();
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1;
    tick(); tick();
    checks++; if ({rx_data, rx_valid, parity_err, frame_err, overrun, rx_busy} !== 13'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {rx_data, rx_valid, parity_err, frame_err, overrun, rx_busy}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    rx_ready = 1'b1;
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", rx_busy); end
    send_frame(8'hA5, 0, 0, 0, 1, -1);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", rx_valid); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", rx_data); end
    checks++; if ({parity_err, frame_err} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b expected 00", {parity_err, frame_err}); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b expected 0", rx_busy); end
    tick();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_one_cycle: got %b expected 0", rx_valid); end
  endtask

  task automatic test_parity();
    rx_ready = 1'b1;
    send_frame(8'h3C, 1, 1, 1, 1, -1);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin errors++; $display("FAIL parity_good_word: got %b/%h expected 1/3c", rx_valid, rx_data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_good_flag: got %b expected 0", parity_err); end
    tick();
    send_frame(8'h3C, 1, 1, 0, 1, -1);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin errors++; $display("FAIL parity_bad_word: got %b/%h expected 1/3c", rx_valid, rx_data); end
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_bad_flag: got %b expected 1", parity_err); end
    tick();
  endtask

  task automatic test_frame_error();
    rx_ready = 1'b1;
    send_frame(8'h55, 0, 0, 0, 0, -1);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin errors++; $display("FAIL ferr_word: got %b/%h expected 1/55", rx_valid, rx_data); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", frame_err); end
    rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_no_restart[%0d]: got %b expected 0", i, rx_busy); end
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_no_new_word: got %b expected 0", rx_valid); end
    rx = 1'b1;
    tick();
    send_frame(8'h66, 0, 0, 0, 1, -1);
    checks++; if (rx_data !== 8'h66 || frame_err !== 1'b0 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL ferr_recover: got %h/%b/%b expected 66/0/1", rx_data, frame_err, rx_valid); end
    tick();
  endtask

  task automatic test_back_to_back_overrun();
    rx_ready = 1'b0;
    send_frame(8'h11, 0, 0, 0, 1, -1);
    checks++; if (rx_data !== 8'h11 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_first: got %h/%b expected 11/0", rx_data, overrun); end
    send_frame(8'h22, 0, 0, 0, 1, -1);
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL b2b_second_data: got %h expected 22", rx_data); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", rx_valid); end
    tick();
    checks++; if (overrun !== 1'b0 || rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_pulse_end: got %b/%b expected 0/1", overrun, rx_valid); end
    rx_ready = 1'b1;
    tick();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept: got %b expected 0", rx_valid); end
  endtask

  task automatic test_load_accept();
    rx_ready = 1'b0;
    send_frame(8'h33, 0, 0, 0, 1, -1);
    send_frame(8'h44, 0, 0, 0, 1, 1);
    checks++; if (overrun !== 1'b0 || rx_valid !== 1'b1 || rx_data !== 8'h44) begin
      errors++; $display("FAIL load_accept: got ovr=%b v=%b d=%h expected 0/1/44", overrun, rx_valid, rx_data); end
    tick();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL load_accept_clear: got %b expected 0", rx_valid); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] f0 = 8'hF0;
    rx_ready = 1'b0;
    send_frame(8'h99, 0, 0, 0, 1, -1);
    rx = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin rx = f0[k]; tick(); end
    rx = f0[3]; rst = 1'b1;
    tick();
    rst = 1'b0; rx = 1'b0;
    checks++; if ({rx_data, rx_valid, parity_err, frame_err, overrun, rx_busy} !== 13'd0) begin
      errors++; $display("FAIL midreset_outputs: got %h expected 0", {rx_data, rx_valid, parity_err, frame_err, overrun, rx_busy}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
        errors++; $display("FAIL midreset_no_start[%0d]: got %b/%b expected 0/0", i, rx_busy, rx_valid); end
    end
    rx = 1'b1; rx_ready = 1'b1;
    tick();
    send_frame(8'h81, 0, 0, 0, 1, -1);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h81 || frame_err !== 1'b0) begin
      errors++; $display("FAIL midreset_next: got %b/%h/%b expected 1/81/0", rx_valid, rx_data, frame_err); end
    tick();
  endtask

  task automatic test_random();
    rx_ready = 1'b1;
    for (int f = 0; f < 24; f++) begin
      logic [7:0] d;
      bit pen, ev, pbit, stop, exp_perr;
      int gap;
      d = 8'($urandom);
      pen = 1'($urandom); ev = 1'($urandom);
      pbit = model_parity(d, ev) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      exp_perr = pen && (pbit != model_parity(d, ev));
      send_frame(d, pen, ev, pbit, stop, -1);
      checks++; if (rx_valid !== 1'b1 || rx_data !== d || parity_err !== exp_perr || frame_err !== !stop || overrun !== 1'b0) begin
        errors++; $display("FAIL random[%0d]: got v=%b d=%h pe=%b fe=%b ov=%b expected 1/%h/%b/%b/0",
                           f, rx_valid, rx_data, parity_err, frame_err, overrun, d, exp_perr, !stop); end
      gap = $urandom_range(0, 2);
      if (!stop && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) tick();
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_error();
    test_back_to_back_overrun();
    test_load_accept();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
